// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART core: FSM state enums,
// parity-mode constants and the frame-length function.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Total bits on the line per frame, including start and stop bits.
  function automatic int frame_bits(input int data_bits, input int parity_en,
                                    input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: fires a one-cycle tick every (div+1) clocks.
// A synchronous clear restarts the count so a new frame starts phase-aligned.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  // Tick is not gated by clear so the TX ready/accept path stays loop-free.
  assign tick = (cnt == div);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_param_core.sv
// Full-duplex UART with runtime baud divisor, configurable frame format and
// an oversampling receiver with false-start rejection; single clock domain.
module uart_param_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 loopback,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  input  logic                 rx_in,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_error,
  output logic                 framing_error
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
  localparam int OS_W       = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      DATA_LAST  = 4'(DATA_BITS);
  localparam logic [3:0]      FRAME_LAST = 4'(FRAME_BITS - 1);
  localparam logic            PAR_MODE   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  // ---------------------------------------------------------------- TX
  tx_state_t              tx_state, tx_state_nxt;
  logic [DIV_WIDTH-1:0]   tx_div;
  logic [OS_W-1:0]        tx_os_cnt;
  logic [3:0]             tx_bit_cnt;
  logic [DATA_BITS-1:0]   tx_sh;
  logic                   tx_par;
  logic                   tx_tick, tx_accept, tx_bit_end, tx_last_stop, tx_line_nxt;

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tx_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tx_accept),
    .div    (tx_div),
    .tick   (tx_tick)
  );

  assign tx_bit_end   = tx_tick && (tx_os_cnt == OS_LAST) && (tx_state != TX_IDLE);
  assign tx_last_stop = (tx_state == TX_STOP) && tx_bit_end && (tx_bit_cnt == FRAME_LAST);
  // Ready already in the final stop-bit cycle so back-to-back frames have no gap.
  assign tx_ready     = (tx_state == TX_IDLE) || tx_last_stop;
  assign tx_accept    = tx_valid && tx_ready;

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:   if (tx_accept) tx_state_nxt = TX_START;
      TX_START:  if (tx_bit_end) tx_state_nxt = TX_DATA;
      TX_DATA: begin
        if (tx_bit_end && (tx_bit_cnt == DATA_LAST)) begin
          if (PARITY_EN != 0) tx_state_nxt = TX_PARITY;
          else                tx_state_nxt = TX_STOP;
        end
      end
      TX_PARITY: if (tx_bit_end) tx_state_nxt = TX_STOP;
      TX_STOP: begin
        if (tx_last_stop) begin
          if (tx_accept) tx_state_nxt = TX_START;
          else           tx_state_nxt = TX_IDLE;
        end
      end
      default:   tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_line_nxt = 1'b1;
    case (tx_state_nxt)
      TX_START:  tx_line_nxt = 1'b0;
      TX_DATA:   tx_line_nxt = (tx_state == TX_START) ? tx_sh[0] : tx_sh[1];
      TX_PARITY: tx_line_nxt = tx_par;
      default:   tx_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state   <= TX_IDLE;
      tx_out     <= 1'b1;
      tx_os_cnt  <= '0;
      tx_bit_cnt <= '0;
      tx_div     <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_accept) begin
        tx_os_cnt  <= '0;
        tx_bit_cnt <= '0;
        tx_div     <= baud_div;
        tx_out     <= 1'b0;
      end else if ((tx_state != TX_IDLE) && tx_tick) begin
        tx_os_cnt <= tx_bit_end ? '0 : tx_os_cnt + 1'b1;
        if (tx_bit_end) begin
          tx_bit_cnt <= tx_bit_cnt + 1'b1;
          tx_out     <= tx_line_nxt;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tx_accept) begin
      tx_sh  <= tx_data;
      tx_par <= (^tx_data) ^ PAR_MODE;
    end else if (tx_bit_end && (tx_state == TX_DATA)) begin
      tx_sh <= tx_sh >> 1;
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_t              rx_state, rx_state_nxt;
  logic [DIV_WIDTH-1:0]   rx_div;
  logic [OS_W-1:0]        rx_os_cnt;
  logic [3:0]             rx_bit_cnt;
  logic [DATA_BITS-1:0]   rx_sh;
  logic                   rx_pbit, rx_ferr;
  logic                   rx_src, rx_s1, rx_s2, rx_prev;
  logic                   rx_tick, rx_fall, rx_start, rx_sample, rx_done;

  assign rx_src = loopback ? tx_out : rx_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_src;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev && !rx_s2;
  // A fresh falling edge during START re-arms the start bit, so a glitch
  // followed closely by a real frame is not lost.
  assign rx_start = rx_fall && ((rx_state == RX_IDLE) || (rx_state == RX_START));

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_rx_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (rx_start),
    .div    (rx_div),
    .tick   (rx_tick)
  );

  always_comb begin
    rx_sample = 1'b0;
    if (rx_tick) begin
      case (rx_state)
        RX_START:                    rx_sample = (rx_os_cnt == OS_MID);
        RX_DATA, RX_PARITY, RX_STOP: rx_sample = (rx_os_cnt == OS_LAST);
        default:                     rx_sample = 1'b0;
      endcase
    end
  end

  assign rx_done = (rx_state == RX_STOP) && rx_sample && (rx_bit_cnt == FRAME_LAST);

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_start) rx_state_nxt = RX_START;
      RX_START: begin
        if (rx_start)       rx_state_nxt = RX_START;
        else if (rx_sample) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_sample && (rx_bit_cnt == DATA_LAST)) begin
          if (PARITY_EN != 0) rx_state_nxt = RX_PARITY;
          else                rx_state_nxt = RX_STOP;
        end
      end
      RX_PARITY: if (rx_sample) rx_state_nxt = RX_STOP;
      RX_STOP:   if (rx_done) rx_state_nxt = RX_IDLE;
      default:   rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state      <= RX_IDLE;
      rx_os_cnt     <= '0;
      rx_bit_cnt    <= '0;
      rx_div        <= '0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_valid <= rx_done;
      if (rx_start) begin
        rx_os_cnt  <= '0;
        rx_bit_cnt <= '0;
        rx_div     <= baud_div;
      end else if ((rx_state != RX_IDLE) && rx_tick) begin
        rx_os_cnt <= rx_sample ? '0 : rx_os_cnt + 1'b1;
        if (rx_sample) rx_bit_cnt <= rx_bit_cnt + 1'b1;
      end
      if (rx_done) begin
        rx_data       <= rx_sh;
        parity_error  <= (PARITY_EN != 0) && (rx_pbit != ((^rx_sh) ^ PAR_MODE));
        framing_error <= rx_ferr || !rx_s2;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rx_sample && (rx_state == RX_DATA)) rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
    if (rx_sample && (rx_state == RX_PARITY)) rx_pbit <= rx_s2;
    if (rx_start) begin
      rx_ferr <= 1'b0;
    end else if (rx_sample && (rx_state == RX_STOP) && !rx_s2) begin
      rx_ferr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_param_core.sv
// Scoreboard bench for uart_param_core: an 8E1 instance (TX timing, loopback,
// rx_in error/false-start frames) and a 7O2 instance (back-to-back, mid-frame reset).
module tb_uart_param_core;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         t_acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t qa[$];
  exp_t qb[$];

  // 8E1 instance
  logic        rst_a_n = 1'b0, loopback_a = 1'b0, tx_valid_a = 1'b0, rx_in_a = 1'b1;
  logic [15:0] baud_div_a = 16'd3;
  logic [7:0]  tx_data_a = '0, rx_data_a;
  logic        tx_ready_a, tx_out_a, rx_valid_a, perr_a, ferr_a;

  // 7O2 instance
  logic        rst_b_n = 1'b0, loopback_b = 1'b1, tx_valid_b = 1'b0, rx_in_b = 1'b1;
  logic [15:0] baud_div_b = 16'd0;
  logic [6:0]  tx_data_b = '0, rx_data_b;
  logic        tx_ready_b, tx_out_b, rx_valid_b, perr_b, ferr_b;

  uart_param_core dut_a (
    .clock(clk), .reset_n(rst_a_n), .baud_div(baud_div_a), .loopback(loopback_a),
    .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a), .tx_out(tx_out_a),
    .rx_in(rx_in_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
    .parity_error(perr_a), .framing_error(ferr_a)
  );

  uart_param_core #(.DATA_BITS(7), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .clock(clk), .reset_n(rst_b_n), .baud_div(baud_div_b), .loopback(loopback_b),
    .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b), .tx_out(tx_out_b),
    .rx_in(rx_in_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
    .parity_error(perr_b), .framing_error(ferr_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level of bit k of a frame: start, LSB-first data, parity, stops.
  function automatic logic frame_bit(input logic [8:0] d, input int nbits,
                                     input logic podd, input int k);
    logic p;
    p = podd;
    for (int i = 0; i < nbits; i++) p = p ^ d[i];
    if (k == 0) return 1'b0;
    if (k <= nbits) return d[k-1];
    if (k == nbits + 1) return p;
    return 1'b1;
  endfunction

  // Drive one 8E1 frame on rx_in of the 8E1 instance (Tb = 64 clocks).
  task automatic send_rx(input logic [7:0] d, input logic flip_par, input logic stop_v);
    logic [10:0] bits;
    bits = {stop_v, (^d) ^ flip_par, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      rx_in_a = bits[k];
      repeat (64) @(negedge clk);
    end
    rx_in_a = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    int   lat;
    if (rx_valid_a) begin
      if (qa.size() == 0) begin
        chk("rxa_spurious_valid", qa.size(), 1);
      end else begin
        e = qa.pop_front();
        chk("rxa_data", rx_data_a, e.data);
        chk("rxa_parity_err", perr_a, e.perr);
        chk("rxa_framing_err", ferr_a, e.ferr);
        if (e.t_acc >= 0) begin
          lat = cyc - e.t_acc;
          chk("rxa_latency", (lat >= 673 && lat <= 675) ? 674 : lat, 674);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rx_valid_b) begin
      if (qb.size() == 0) begin
        chk("rxb_spurious_valid", qb.size(), 1);
      end else begin
        e = qb.pop_front();
        chk("rxb_data", rx_data_b, e.data);
        chk("rxb_parity_err", perr_b, e.perr);
        chk("rxb_framing_err", ferr_b, e.ferr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, ready_lat;
    logic acc2;

    repeat (5) @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_out", tx_out_a, 1);
    chk("rst_tx_ready", tx_ready_a, 1);
    chk("rst_rx_valid", rx_valid_a, 0);
    chk("rst_rx_data", rx_data_a, 0);
    chk("rst_parity_err", perr_a, 0);
    chk("rst_framing_err", ferr_a, 0);
    chk("rst_b_tx_out", tx_out_b, 1);
    chk("rst_b_tx_ready", tx_ready_b, 1);

    // 8E1 0xA5 in loopback: line shape, ready timing, and RX latency
    loopback_a = 1'b1;
    tx_data_a  = 8'hA5;
    tx_valid_a = 1'b1;
    @(negedge clk);
    t0 = cyc;
    tx_valid_a = 1'b0;
    qa.push_back('{9'h0A5, 1'b0, 1'b0, t0});
    chk("txa_ready_low", tx_ready_a, 0);
    ready_lat = -1;
    for (int i = 0; i <= 704; i++) begin
      if (i <= 703 && ((i % 64) == 0 || (i % 64) == 63))
        chk($sformatf("txa_bit%0d_at%0d", i / 64, i), tx_out_a, frame_bit(9'h0A5, 8, 1'b0, i / 64));
      if (ready_lat < 0 && tx_ready_a) ready_lat = i + 1;
      @(negedge clk);
    end
    chk("txa_ready_return", ready_lat, 704);
    for (int i = 0; i < 200 && qa.size() != 0; i++) @(negedge clk);
    chk("rxa_loop_drained", qa.size(), 0);

    // External rx_in frames: bad parity, bad stop, then a clean frame
    loopback_a = 1'b0;
    repeat (20) @(negedge clk);
    qa.push_back('{9'h03C, 1'b1, 1'b0, -1});
    send_rx(8'h3C, 1'b1, 1'b1);
    qa.push_back('{9'h03C, 1'b0, 1'b1, -1});
    send_rx(8'h3C, 1'b0, 1'b0);
    qa.push_back('{9'h05A, 1'b0, 1'b0, -1});
    send_rx(8'h5A, 1'b0, 1'b1);

    // False start: 20-clock low pulse, then a real frame 10 clocks later
    rx_in_a = 1'b0;
    repeat (20) @(negedge clk);
    rx_in_a = 1'b1;
    repeat (10) @(negedge clk);
    qa.push_back('{9'h096, 1'b0, 1'b0, -1});
    send_rx(8'h96, 1'b0, 1'b1);
    chk("rxa_ext_drained", qa.size(), 0);

    // 7O2 back-to-back at baud_div=0 (Tb=16, 176-clock frames)
    tx_data_b  = 7'h55;
    tx_valid_b = 1'b1;
    @(negedge clk);
    t0 = cyc;
    t1 = t0;
    qb.push_back('{9'h055, 1'b0, 1'b0, -1});
    tx_data_b = 7'h2A;
    acc2 = 1'b0;
    for (int i = 1; i <= 400 && !acc2; i++) begin
      @(negedge clk);
      if ((i % 16) == 8)
        chk($sformatf("txb_f1_bit%0d", i / 16), tx_out_b, frame_bit(9'h055, 7, 1'b1, i / 16));
      if (tx_ready_b) begin
        @(negedge clk);
        t1 = cyc;
        tx_valid_b = 1'b0;
        acc2 = 1'b1;
      end
    end
    chk("txb_second_accept", acc2, 1);
    chk("txb_b2b_spacing", t1 - t0, 176);
    chk("txb_f2_start_no_gap", tx_out_b, 0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if ((k % 16) == 8)
        chk($sformatf("txb_f2_bit%0d", k / 16), tx_out_b, frame_bit(9'h02A, 7, 1'b1, k / 16));
    end

    // Asynchronous reset in the middle of the second frame
    #3;
    rst_b_n = 1'b0;
    #1;
    chk("rstmid_tx_out", tx_out_b, 1);
    chk("rstmid_tx_ready", tx_ready_b, 1);
    chk("rstmid_rx_valid", rx_valid_b, 0);
    chk("rstmid_rx_data", rx_data_b, 0);
    repeat (3) @(negedge clk);
    rst_b_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("rxb_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_param_core.md
# uart_param_core

Parametrised full-duplex UART core: a single-clock TX/RX pair with a runtime baud divisor, a configurable frame format (data bits, parity, stop bits) and an oversampling receiver with false-start rejection. It replaces the fixed 8-bit derived-clock UART. All logic runs on the system clock with tick enables, and no internally generated clocks exist. An internal loopback mode keeps the existing TX→RX self-test path available.

## Interface
- DATA_BITS, 8: payload bits per frame, legal 5..9.
- OVERSAMPLE, 16: ticks per bit, even, ≥4.
- DIV_WIDTH, 16: width of baud_div.
- PARITY_EN, 1: 1 inserts and checks a parity bit.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd.
- STOP_BITS, 1: 1 or 2.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- baud_div  in  DIV_WIDTH  tick period = baud_div+1 clocks; bit period Tb = OVERSAMPLE·(baud_div+1).
- loopback  in  1  1 feeds the RX from tx_out instead of rx_in.
- tx_valid  in  1  TX request.
- tx_data  in  DATA_BITS  TX payload.
- tx_ready  out  1  TX idle, can accept.
- tx_out  out  1  serial line out, idles high.
- rx_in  in  1  serial line in, asynchronous.
- rx_valid  out  1  one-cycle pulse, frame received.
- rx_data  out  DATA_BITS  last received payload, held until the next frame.
- parity_error  out  1  parity mismatch; valid with rx_valid, held.
- framing_error  out  1  a stop bit sampled 0; valid with rx_valid, held.

## Operation
- Reset values: tx_out=1, tx_ready=1, rx_valid=0, rx_data=0, parity_error=0, framing_error=0; both FSMs in IDLE; tick counters at 0.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if !PARITY_EN) → STOP → IDLE.
  - Acceptance occurs when tx_valid && tx_ready. On acceptance: latch tx_data and baud_div, clear the TX tick counter, leave IDLE.
  - Data is sent LSB first.
  - The parity bit is the XOR of the data bits, XOR PARITY_ODD.
  - STOP lasts STOP_BITS bit periods.
- RX path: rx source = loopback ? tx_out : rx_in. The source goes through a 2-flop synchroniser (reset value 1).
- RX FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: a synchronised 1→0 edge clears the RX tick counter, latches baud_div, and enters START.
  - START: at tick OVERSAMPLE/2, if the line is 1, return to IDLE (false start) with no rx_valid.
  - Sampling: each later bit is sampled once, OVERSAMPLE ticks after the previous sample point (mid-bit).
  - STOP: every stop bit is sampled; any 0 sets framing_error.
  - Completion: at the last stop sample, pulse rx_valid and update rx_data, parity_error and framing_error in the same cycle, then go to IDLE.
  - A frame with a framing error still reports rx_data.
- No RX buffering: a consumer that misses the rx_valid pulse loses the frame.
- Full duplex: TX and RX are fully independent. Simultaneous TX acceptance and RX completion are both handled in the same cycle.

## Timing
- Tick generation: a tick fires when the counter equals the latched divisor, then the counter wraps to 0. baud_div=0 means a tick every clock.
- baud_div changes take effect only at the next frame start (TX acceptance or RX start edge). They never apply mid-frame.
- TX bit timing: the start bit appears on tx_out the cycle after acceptance. Every bit lasts exactly Tb clocks.
- TX frame length: N = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits.
- tx_ready: deasserts the cycle after acceptance and reasserts after N·Tb clocks. Back-to-back frames therefore have no idle gap.
- RX latency: rx_valid fires 2 (synchroniser) + 1 (edge detect) + (N−1)·Tb + Tb/2 clocks after the line's falling edge, ±1 clock.
- Reset mid-frame: asserting reset_n low immediately forces all outputs to their reset values. A partial frame is discarded with no rx_valid.

## Structure
- Shared package uart_pkg holds:
  - the TX and RX state enums;
  - the parity-mode constants;
  - a frame-length function frame_bits(DATA_BITS, PARITY_EN, STOP_BITS).
- Sub-module uart_baud_tick (DIV_WIDTH): divisor counter with a synchronous clear and a tick output. Instantiated twice, one for TX and one for RX.
- TX and RX FSMs live in uart_param_core. Target size: 250–350 lines.

## Test plan
- 8E1, baud_div=3 (Tb=64), tx 0xA5:
  - tx_out sequence is 0,1,0,1,0,0,1,0,1,0,1, each bit held 64 clocks.
  - tx_ready returns 704 clocks after acceptance.
- Loopback 8E1, 0xA5: rx_valid fires once, 674±1 clocks after acceptance, with rx_data=0xA5, parity_error=0, framing_error=0.
- rx_in frame 0x3C with the parity bit inverted → rx_valid with rx_data=0x3C, parity_error=1.
- rx_in frame 0x3C with the stop bit driven 0 → rx_valid with framing_error=1. The next good frame clears the flag.
- False start: rx_in low for 20 clocks at Tb=64, then high → no rx_valid; the RX accepts a valid frame starting 10 clocks later.
- 7O2 (DATA_BITS=7, PARITY_ODD=1, STOP_BITS=2), baud_div=0:
  - Back-to-back tx 0x55 then 0x2A: 11-bit frames with no gap between them.
  - Reset asserted mid-second-frame: tx_out=1 and tx_ready=1 immediately, with no rx_valid.
